// File: rtl/router_pkt_tx.sv
// Packet source for the 1x3 router. It buffers a payload, then sends a header,
// the payload bytes and a parity byte, and samples the router error flag after each packet.
module router_pkt_tx #(
  parameter int MAX_LEN = 63,
  parameter int IFG     = 2,
  parameter int ERR_WIN = 3
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  input  logic [1:0] addr,
  input  logic [5:0] len,
  input  logic       inj_err,
  output logic       req_ready,
  output logic       req_rej,
  input  logic [7:0] pl_data,
  input  logic       pl_valid,
  output logic       pl_ready,
  output logic [7:0] tx_data,
  output logic       pkt_valid,
  input  logic       busy,
  output logic       done,
  output logic       tx_err,
  input  logic       error,
  output logic [2:0] state
);

  // Handshakes:
  //   request : taken on an edge where start & req_ready (req_ready only in IDLE).
  //   payload : a byte is taken on an edge where pl_valid & pl_ready (pl_ready only in LOAD).
  //   wire    : the presented byte is consumed on an edge where busy == 0 in HEADER,
  //             PAYLOAD or PARITY; while busy == 1, tx_data and pkt_valid hold.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_HEADER  = 3'd2,
    S_PAYLOAD = 3'd3,
    S_PARITY  = 3'd4,
    S_ERRWAIT = 3'd5,
    S_GAP     = 3'd6
  } state_t;

  localparam int CW = 4;
  localparam logic [CW-1:0] WIN_LAST = CW'(ERR_WIN - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(IFG - 1);

  state_t cur, nxt;

  logic [5:0]    len_q;
  logic [1:0]    addr_q;
  logic          inj_q;
  logic [5:0]    wr_cnt;
  logic [5:0]    rd_ptr;
  logic [7:0]    parity;
  logic [CW-1:0] win_cnt;
  logic [CW-1:0] gap_cnt;
  logic          legal;
  logic [7:0]    mem [0:MAX_LEN-1];

  assign legal = (addr != 2'd3) && (len != 6'd0) && (int'(len) <= MAX_LEN);
  assign state = cur;

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) cur <= S_IDLE;
    else       cur <= nxt;
  end

  // Next-state logic
  always_comb begin
    nxt = cur;
    case (cur)
      S_IDLE:    if (start && legal) nxt = S_LOAD;
      S_LOAD:    if (pl_valid && (wr_cnt == len_q - 6'd1)) nxt = S_HEADER;
      S_HEADER:  if (!busy) nxt = S_PAYLOAD;
      S_PAYLOAD: if (!busy && (rd_ptr == len_q - 6'd1)) nxt = S_PARITY;
      S_PARITY:  if (!busy) nxt = S_ERRWAIT;
      S_ERRWAIT: if (win_cnt == WIN_LAST) nxt = S_GAP;
      S_GAP:     if (gap_cnt == GAP_LAST) nxt = S_IDLE;
      default:   nxt = S_IDLE;
    endcase
  end

  // Output logic; wire outputs depend only on registered state, so they hold under busy.
  always_comb begin
    tx_data   = 8'd0;
    pkt_valid = 1'b0;
    case (cur)
      S_HEADER: begin
        tx_data   = {len_q, addr_q};
        pkt_valid = 1'b1;
      end
      S_PAYLOAD: begin
        tx_data   = mem[rd_ptr];
        pkt_valid = 1'b1;
      end
      S_PARITY: tx_data = parity ^ {7'd0, inj_q};
      default: ;
    endcase
    req_ready = (cur == S_IDLE);
    pl_ready  = (cur == S_LOAD);
    done      = (cur == S_GAP) && (gap_cnt == GAP_LAST);
  end

  // Request capture, pointers, parity, error window and gap counting
  always_ff @(posedge clk) begin
    if (!rstn) begin
      len_q   <= 6'd0;
      addr_q  <= 2'd0;
      inj_q   <= 1'b0;
      wr_cnt  <= 6'd0;
      rd_ptr  <= 6'd0;
      parity  <= 8'd0;
      win_cnt <= '0;
      gap_cnt <= '0;
      tx_err  <= 1'b0;
      req_rej <= 1'b0;
    end else begin
      req_rej <= (cur == S_IDLE) && start && !legal;
      case (cur)
        S_IDLE: begin
          if (start && legal) begin
            len_q   <= len;
            addr_q  <= addr;
            inj_q   <= inj_err;
            tx_err  <= 1'b0;
            wr_cnt  <= 6'd0;
            rd_ptr  <= 6'd0;
            win_cnt <= '0;
            gap_cnt <= '0;
          end
        end
        S_LOAD: if (pl_valid) wr_cnt <= wr_cnt + 6'd1;
        S_HEADER: if (!busy) parity <= {len_q, addr_q};
        S_PAYLOAD: begin
          if (!busy) begin
            parity <= parity ^ mem[rd_ptr];
            rd_ptr <= rd_ptr + 6'd1;
          end
        end
        S_ERRWAIT: begin
          win_cnt <= win_cnt + 1'b1;
          if (error) tx_err <= 1'b1;
        end
        S_GAP: gap_cnt <= gap_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  // Payload buffer is plain storage; wr_cnt/rd_ptr define which entries are live.
  always_ff @(posedge clk) begin
    if ((cur == S_LOAD) && pl_valid) mem[wr_cnt] <= pl_data;
  end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Bench for router_pkt_tx: directed packets, a router model driving busy/error,
// and a wire monitor that checks each consumed byte against an expected queue.
module tb_router_pkt_tx;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       start = 1'b0;
  logic [1:0] addr = 2'd0;
  logic [5:0] len = 6'd0;
  logic       inj_err = 1'b0;
  logic       req_ready, req_rej, pl_ready;
  logic [7:0] pl_data = 8'd0;
  logic       pl_valid = 1'b0;
  logic [7:0] tx_data;
  logic       pkt_valid;
  logic       busy = 1'b0;
  logic       done, tx_err;
  logic       error = 1'b0;
  logic [2:0] state;

  int tests = 0;
  int failed = 0;

  logic [8:0] exp_q[$];
  logic [7:0] pay [0:63];

  // Router model controls
  logic       busy_arm = 1'b0;
  logic [7:0] busy_trig = 8'd0;
  int         busy_cnt = 0;
  logic       err_arm = 1'b0;
  int         err_timer = 0;
  logic       err_noise = 1'b0;

  // Monitor state
  int         cyc = 0;
  int         par_cyc = 0;
  logic       in_pkt = 1'b0;
  logic       prev_hold = 1'b0;
  logic [8:0] prev_word = 9'd0;
  logic       gap_arm = 1'b0;
  int         gap_exp = 0;
  logic       gap_seen = 1'b0;

  router_pkt_tx #(.MAX_LEN(63), .IFG(2), .ERR_WIN(3)) dut (
    .clk(clk), .rstn(rstn), .start(start), .addr(addr), .len(len), .inj_err(inj_err),
    .req_ready(req_ready), .req_rej(req_rej), .pl_data(pl_data), .pl_valid(pl_valid),
    .pl_ready(pl_ready), .tx_data(tx_data), .pkt_valid(pkt_valid), .busy(busy),
    .done(done), .tx_err(tx_err), .error(error), .state(state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Router model: stalls on a trigger byte, raises error two cycles after parity
  always @(negedge clk) begin
    if (busy_cnt > 0) begin
      busy = 1'b1;
      busy_cnt--;
    end else if (busy_arm && pkt_valid && tx_data == busy_trig) begin
      busy = 1'b1;
      busy_cnt = 3;
      busy_arm = 1'b0;
    end else begin
      busy = 1'b0;
    end
    if (err_timer > 0) begin
      error = (err_timer == 1);
      err_timer--;
    end else begin
      error = err_noise && pl_ready;
    end
  end

  // Wire monitor: samples just before each rising edge
  always @(negedge clk) begin
    logic [8:0] got, exp;
    #2;
    cyc++;
    got = {pkt_valid, tx_data};
    if (!rstn) begin
      in_pkt = 1'b0;
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        tests++;
        if (got !== prev_word) begin
          failed++;
          $display("FAIL hold: got %h expected %h", got, prev_word);
        end
      end
      prev_hold = busy && (pkt_valid || in_pkt);
      prev_word = got;
      if (!busy && (pkt_valid || in_pkt)) begin
        tests++;
        if (exp_q.size() == 0) begin
          failed++;
          $display("FAIL wire_extra: got %h expected none", got);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            failed++;
            $display("FAIL wire_byte: got %h expected %h", got, exp);
          end
        end
        if (pkt_valid && !in_pkt && gap_arm) begin
          tests++;
          gap_seen = 1'b1;
          if (cyc - par_cyc - 1 != gap_exp) begin
            failed++;
            $display("FAIL gap: got %0d expected %0d", cyc - par_cyc - 1, gap_exp);
          end
        end
        if (!pkt_valid) begin
          in_pkt = 1'b0;
          par_cyc = cyc;
          if (err_arm) err_timer = 2;
        end else begin
          in_pkt = 1'b1;
        end
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", req_ready, 1);
  endtask

  task automatic send_pkt(input logic [1:0] a, input logic [5:0] l, input logic inj,
                          input logic exp_err);
    logic [7:0] p;
    int n;
    wait_idle();
    p = {l, a};
    exp_q.push_back({1'b1, p});
    for (int i = 0; i < int'(l); i++) begin
      exp_q.push_back({1'b1, pay[i]});
      p = p ^ pay[i];
    end
    exp_q.push_back({1'b0, p ^ {7'd0, inj}});
    start = 1'b1; addr = a; len = l; inj_err = inj;
    @(negedge clk);
    start = 1'b0;
    chk("load_pl_ready", pl_ready, 1);
    chk("load_req_ready", req_ready, 0);
    chk("load_tx_err", tx_err, 0);
    for (int i = 0; i < int'(l); i++) begin
      pl_valid = 1'b1; pl_data = pay[i];
      @(negedge clk);
    end
    pl_valid = 1'b0; pl_data = 8'd0;
    n = 0;
    while (done !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", done, 1);
    chk("tx_err", tx_err, exp_err);
  endtask

  task automatic reject(input logic [1:0] a, input logic [5:0] l);
    wait_idle();
    start = 1'b1; addr = a; len = l;
    @(negedge clk);
    start = 1'b0;
    chk("rej_pulse", req_rej, 1);
    chk("rej_ready", req_ready, 1);
    @(negedge clk);
    chk("rej_clear", req_rej, 0);
    chk("rej_no_load", pl_ready, 0);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_pkt_valid", pkt_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_pl_ready", pl_ready, 0);
    chk("rst_req_rej", req_rej, 0);
    chk("rst_done", done, 0);
    chk("rst_tx_err", tx_err, 0);
    rstn = 1'b1;
    @(negedge clk);

    // Basic packet: header 0D, payload 11 22 33
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
    send_pkt(2'd1, 6'd3, 1'b0, 1'b0);

    // Same packet with a 4-cycle stall on byte 22
    busy_trig = 8'h22; busy_arm = 1'b1;
    send_pkt(2'd1, 6'd3, 1'b0, 1'b0);

    // Illegal requests
    reject(2'd3, 6'd5);
    reject(2'd0, 6'd0);

    // Max length, injected parity error, router error inside the window
    for (int i = 0; i < 63; i++) pay[i] = 8'(i * 7 + 5);
    err_arm = 1'b1;
    send_pkt(2'd2, 6'd63, 1'b1, 1'b1);
    err_arm = 1'b0;
    repeat (4) @(negedge clk);
    chk("tx_err_holds", tx_err, 1);

    // Reset while payload byte 5 of 10 is on the wire
    for (int i = 0; i < 10; i++) pay[i] = 8'(8'hA0 + i);
    exp_q.push_back({1'b1, 8'h28});
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b1, pay[i]});
    start = 1'b1; addr = 2'd0; len = 6'd10; inj_err = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("clear_tx_err_on_start", tx_err, 0);
    for (int i = 0; i < 10; i++) begin
      pl_valid = 1'b1; pl_data = pay[i];
      @(negedge clk);
    end
    pl_valid = 1'b0; pl_data = 8'd0;
    n = 0;
    while (!(pkt_valid === 1'b1 && tx_data === pay[4]) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("byte5_seen", tx_data, pay[4]);
    rstn = 1'b0;
    @(negedge clk);
    chk("mid_rst_pkt_valid", pkt_valid, 0);
    chk("mid_rst_tx_data", tx_data, 0);
    chk("mid_rst_req_ready", req_ready, 1);
    rstn = 1'b1;
    @(negedge clk);
    chk("abandoned_flushed", exp_q.size(), 0);

    // Clean packet after reset; error outside the window must be ignored
    err_noise = 1'b1;
    send_pkt(2'd0, 6'd5, 1'b0, 1'b0);
    err_noise = 1'b0;

    // Back-to-back: ERRWAIT + GAP + IDLE + LOAD cycles between parity and header
    pay[0] = 8'h5A; pay[1] = 8'hC3; pay[2] = 8'h0F; pay[3] = 8'hF0; pay[4] = 8'h81; pay[5] = 8'h7E;
    send_pkt(2'd2, 6'd4, 1'b0, 1'b0);
    gap_exp = 3 + 2 + 1 + 6;
    gap_arm = 1'b1;
    send_pkt(2'd0, 6'd6, 1'b0, 1'b0);
    gap_arm = 1'b0;
    chk("gap_measured", gap_seen, 1);

    repeat (4) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
